// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
//   arb_state_e : arbiter FSM encoding
//   mem_req_t   : one memory request at the default widths
package mem_arb_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8;
  localparam int MEM_NUM_REQ    = 2;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic [MEM_STRB_WIDTH-1:0] wstrb;
    logic                      write;
    logic                      read;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   active     : requesters currently asking for the port
//   last_grant : index served most recently; search starts one above it
//   pick       : one-hot winner (0 when nothing is active)
//   pick_idx   : binary index of the winner
//   any        : at least one requester is active
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic found;

  // Walk last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); the last step
  // revisits last_grant itself so a lone requester can win repeatedly.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && active[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
    any = |active;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// The winning request is captured into req_q and driven downstream unchanged
// until dmem_ready_i; ready and read data go back only to the granted index.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_addr_i/wdata_i/wstrb_i  per-requester request payload (packed arrays)
//   req_write_i, req_read_i     per-requester request type (write wins if both)
//   req_rdata_o, req_ready_o    completion back to the granted requester
//   dmem_*_o                    downstream request, all zero when idle
//   dmem_rdata_i, dmem_ready_i  downstream completion
//   grant_o, busy_o             registered one-hot grant and busy flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// ArbIdle | no downstream request; pick and capture a winner if any
// ArbBusy | req_q driven downstream; wait for dmem_ready_i
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int NUM_REQ    = MEM_NUM_REQ
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  req_wstrb_i,
  input  logic [NUM_REQ-1:0]                    req_write_i,
  input  logic [NUM_REQ-1:0]                    req_read_i,
  output logic [DATA_WIDTH-1:0]                 req_rdata_o,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  output logic [ADDR_WIDTH-1:0]                 dmem_addr_o,
  output logic [DATA_WIDTH-1:0]                 dmem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]               dmem_wstrb_o,
  output logic                                  dmem_write_o,
  output logic                                  dmem_read_o,
  input  logic [DATA_WIDTH-1:0]                 dmem_rdata_i,
  input  logic                                  dmem_ready_i,
  output logic [NUM_REQ-1:0]                    grant_o,
  output logic                                  busy_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  // Same layout as mem_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  write;
    logic                  read;
  } req_reg_t;

  arb_state_e         state_q, state_d;
  req_reg_t           req_q, req_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               busy;
  logic               done;

  assign active = req_write_i | req_read_i;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .active     (active),
    .last_grant (last_grant_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ArbIdle;
      req_q        <= '0;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ArbIdle: begin
        if (pick_any) begin
          req_d.addr  = req_addr_i[pick_idx];
          req_d.wdata = req_wdata_i[pick_idx];
          req_d.wstrb = req_wstrb_i[pick_idx];
          // Winner is active, so "not a write" means a read.
          req_d.write = req_write_i[pick_idx];
          req_d.read  = ~req_write_i[pick_idx];
          grant_d     = pick;
          grant_idx_d = pick_idx;
          state_d     = ArbBusy;
        end
      end
      ArbBusy: begin
        if (dmem_ready_i) begin
          last_grant_d = grant_idx_q;
          grant_d      = '0;
          state_d      = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  assign busy = (state_q == ArbBusy);
  assign done = busy & dmem_ready_i;

  // req_q keeps its last contents in ArbIdle, so downstream is gated by busy.
  assign dmem_addr_o  = busy ? req_q.addr  : '0;
  assign dmem_wdata_o = busy ? req_q.wdata : '0;
  assign dmem_wstrb_o = busy ? req_q.wstrb : '0;
  assign dmem_write_o = busy & req_q.write;
  assign dmem_read_o  = busy & req_q.read;

  assign req_ready_o = done ? grant_q : '0;
  assign req_rdata_o = done ? dmem_rdata_i : '0;

  assign grant_o = grant_q;
  assign busy_o  = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0][31:0] req_addr_i;
  logic [1:0][31:0] req_wdata_i;
  logic [1:0][3:0]  req_wstrb_i;
  logic [1:0]       req_write_i;
  logic [1:0]       req_read_i;
  logic [31:0]      req_rdata_o;
  logic [1:0]       req_ready_o;
  logic [31:0]      dmem_addr_o;
  logic [31:0]      dmem_wdata_o;
  logic [3:0]       dmem_wstrb_o;
  logic             dmem_write_o;
  logic             dmem_read_o;
  logic [31:0]      dmem_rdata_i;
  logic             dmem_ready_i;
  logic [1:0]       grant_o;
  logic             busy_o;

  mem_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REQ    (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_wstrb_i  (req_wstrb_i),
    .req_write_i  (req_write_i),
    .req_read_i   (req_read_i),
    .req_rdata_o  (req_rdata_o),
    .req_ready_o  (req_ready_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_wstrb_o (dmem_wstrb_o),
    .dmem_write_o (dmem_write_o),
    .dmem_read_o  (dmem_read_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ready_i (dmem_ready_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  grant;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] g, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd);
    exp_t e;
    e.grant = g; e.wr = w; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Inputs change just after the rising edge; outputs are read on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    req_write_i = '0;
    req_read_i  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  dmem_addr_o, 0);
    chk({tag, "_wdata"}, dmem_wdata_o, 0);
    chk({tag, "_wstrb"}, dmem_wstrb_o, 0);
    chk({tag, "_wr"},    dmem_write_o, 0);
    chk({tag, "_rd"},    dmem_read_o, 0);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_rdata"}, req_rdata_o, 0);
  endtask

  // Scoreboard: every downstream completion must match the next expected transaction.
  always @(negedge clk) begin
    if (rst_n && busy_o && dmem_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_txn", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_grant", grant_o, mon_e.grant);
        chk("sb_ready", req_ready_o, mon_e.grant);
        chk("sb_addr",  dmem_addr_o, mon_e.addr);
        chk("sb_write", dmem_write_o, mon_e.wr);
        chk("sb_read",  dmem_read_o, !mon_e.wr);
        if (mon_e.wr) begin
          chk("sb_wdata", dmem_wdata_o, mon_e.wdata);
          chk("sb_wstrb", dmem_wstrb_o, mon_e.wstrb);
        end else begin
          chk("sb_rdata", req_rdata_o, mon_e.rdata);
        end
        n_done++;
      end
    end
  end

  int base;

  initial begin
    rst_n        = 1'b0;
    dmem_rdata_i = '0;
    dmem_ready_i = 1'b0;
    clear_reqs();

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    tick();
    rst_n = 1'b1;

    // Single read from requester 1
    req_read_i[1] = 1'b1;
    req_addr_i[1] = 32'h100;
    push_exp(2'b10, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    tick();
    dmem_ready_i = 1'b1;
    dmem_rdata_i = 32'hDEADBEEF;
    clear_reqs();
    @(negedge clk);
    chk("t1_grant", grant_o, 2'b10);
    chk("t1_busy", busy_o, 1);
    chk("t1_rdata", req_rdata_o, 32'hDEADBEEF);
    tick();
    dmem_ready_i = 1'b0;
    @(negedge clk);
    chk_all_zero("t1_idle");

    // Both requesters continuously active, memory always ready
    base = n_done;
    dmem_ready_i = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    req_read_i[0]  = 1'b1;
    req_addr_i[0]  = 32'h200;
    req_write_i[1] = 1'b1;
    req_addr_i[1]  = 32'h300;
    req_wdata_i[1] = 32'h11112222;
    req_wstrb_i[1] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      push_exp(2'b01, 1'b0, 32'h200, 32'h0, 4'h0, 32'hCAFEF00D);
      push_exp(2'b10, 1'b1, 32'h300, 32'h11112222, 4'b1111, 32'h0);
    end
    repeat (11) tick();
    clear_reqs();
    tick();
    dmem_ready_i = 1'b0;
    chk("rr_six_in_12", n_done - base, 6);

    // Write stalled 5 cycles; requester 0 drops its inputs in cycle 2
    req_write_i[0] = 1'b1;
    req_addr_i[0]  = 32'h40;
    req_wdata_i[0] = 32'h12345678;
    req_wstrb_i[0] = 4'b0011;
    push_exp(2'b01, 1'b1, 32'h40, 32'h12345678, 4'b0011, 32'h0);
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        clear_reqs();
        req_addr_i[0] = 32'hFFFF_0000;
      end
      @(negedge clk);
      chk("stall_addr",  dmem_addr_o, 32'h40);
      chk("stall_wdata", dmem_wdata_o, 32'h12345678);
      chk("stall_wstrb", dmem_wstrb_o, 4'b0011);
      chk("stall_wr",    dmem_write_o, 1);
      chk("stall_rd",    dmem_read_o, 0);
      chk("stall_ready", req_ready_o, 0);
      tick();
    end
    dmem_ready_i = 1'b1;
    tick();
    dmem_ready_i = 1'b0;
    req_addr_i[0] = '0;

    // Write and read both set: treated as a write
    req_write_i[0] = 1'b1;
    req_read_i[0]  = 1'b1;
    req_addr_i[0]  = 32'h80;
    req_wdata_i[0] = 32'hA5A5A5A5;
    req_wstrb_i[0] = 4'b1111;
    dmem_ready_i   = 1'b1;
    push_exp(2'b01, 1'b1, 32'h80, 32'hA5A5A5A5, 4'b1111, 32'h0);
    @(negedge clk);
    chk("wr_rd_idle_ready", req_ready_o, 0);
    tick();
    clear_reqs();
    tick();
    dmem_ready_i = 1'b0;

    // Reset while busy, then simultaneous requests restart at requester 0
    req_read_i[1] = 1'b1;
    req_addr_i[1] = 32'h500;
    tick();
    @(negedge clk);
    chk("rb_busy", busy_o, 1);
    chk("rb_dmem_rd", dmem_read_o, 1);
    #1;
    rst_n        = 1'b0;
    dmem_ready_i = 1'b1;
    #1;
    chk_all_zero("rb_async");
    tick();
    clear_reqs();
    dmem_ready_i = 1'b0;
    tick();
    rst_n = 1'b1;
    req_read_i    = 2'b11;
    req_addr_i[0] = 32'h600;
    req_addr_i[1] = 32'h700;
    dmem_ready_i  = 1'b1;
    dmem_rdata_i  = 32'h0BADF00D;
    push_exp(2'b01, 1'b0, 32'h600, 32'h0, 4'h0, 32'h0BADF00D);
    push_exp(2'b10, 1'b0, 32'h700, 32'h0, 4'h0, 32'h0BADF00D);
    repeat (3) tick();
    clear_reqs();
    tick();
    dmem_ready_i = 1'b0;

    // dmem_ready pulsed while idle
    tick();
    dmem_ready_i = 1'b1;
    @(negedge clk);
    chk("idle_pulse_ready", req_ready_o, 0);
    chk("idle_pulse_busy", busy_o, 0);
    tick();
    dmem_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_after_busy", busy_o, 0);
    chk("idle_after_grant", grant_o, 0);

    repeat (2) tick();
    chk("sb_left_over", exp_q.size(), 0);
    chk("txn_total", n_done, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single data-memory port among `NUM_REQ` requesters, for example a direct-mapped write-back cache's fill/writeback port and an instruction fetch port. Each requester uses the same valid/ready memory handshake as the cache-to-memory interface. The arbiter captures the winning request into registers, drives it downstream, and returns read data and ready only to the granted requester. It sits between the L1 controllers and the memory model or bus bridge.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width; strobe width is `DATA_WIDTH/8`
- `NUM_REQ`, 2, number of requesters (≥2)
- `clk`  in  1  clock, single domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_addr_i`  in  `NUM_REQ`×`ADDR_WIDTH`  per-requester address (packed array)
- `req_wdata_i`  in  `NUM_REQ`×`DATA_WIDTH`  per-requester write data
- `req_wstrb_i`  in  `NUM_REQ`×`DATA_WIDTH/8`  per-requester byte strobes
- `req_write_i`  in  `NUM_REQ`  write request
- `req_read_i`  in  `NUM_REQ`  read request
- `req_rdata_o`  out  `DATA_WIDTH`  read data, shared bus, qualified by `req_ready_o`
- `req_ready_o`  out  `NUM_REQ`  per-requester completion, at most one bit set
- `dmem_addr_o`, `dmem_wdata_o`, `dmem_wstrb_o`, `dmem_write_o`, `dmem_read_o`  out  downstream request
- `dmem_rdata_i`  in  `DATA_WIDTH`  downstream read data
- `dmem_ready_i`  in  1  downstream completion
- `grant_o`  out  `NUM_REQ`  one-hot current grant; 0 when idle
- `busy_o`  out  1  high in ArbBusy

## Operation
- A requester is active when `req_write_i[i] | req_read_i[i]`.
- If both are set, the access is a write. Read data is don't-care and the strobe is taken as given.
- States:
  - ArbIdle: no downstream request. If any requester is active, pick a winner round-robin, starting at `last_grant+1` and wrapping modulo `NUM_REQ`. Register the winner's addr, wdata, wstrb and write/read into `req_q`. Set `grant_q` and go to ArbBusy.
  - ArbBusy: drive `dmem_*` from `req_q` only. Exactly one of `dmem_write_o`/`dmem_read_o` is high.
  - When `dmem_ready_i` is high in ArbBusy:
    - `req_ready_o[grant]` = 1 and `req_rdata_o` = `dmem_rdata_i` in the same cycle (combinational pass-through).
    - `last_grant` ← grant and return to ArbIdle.
- The captured request is immune to the requester changing or dropping its inputs while in ArbBusy. Ready is still returned to the granted index.
- Requesters deassert, or present a new request, in the cycle after their ready. A request still asserted in ArbIdle is treated as a new transaction.
- Requesters not granted see `req_ready_o` = 0 and must hold their request. There is no timeout; `dmem_ready_i` may stall indefinitely.
- In ArbIdle all `dmem_*` outputs are 0. `dmem_ready_i` in ArbIdle is ignored.
- Reset, asynchronous with `rst_n` low, including mid-transaction:
  - state ArbIdle; `req_q` = 0; `grant_q` = 0; `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
  - All outputs 0. An in-flight transaction is abandoned with no ready returned.

## Timing
- Request sampled at edge k (ArbIdle) → downstream request visible from cycle k+1.
- With `dmem_ready_i` already high in cycle k+1, `req_ready_o` is high in cycle k+1. Minimum latency is 1 cycle from the sampled edge to ready.
- Back-to-back: one mandatory ArbIdle cycle between transactions. Peak throughput is one transaction per 2 cycles.
- Simultaneous requests from all requesters are served in strict rotation. Each waits at most `NUM_REQ-1` transactions.
- `grant_o` and `busy_o` are registered. `req_ready_o` and `req_rdata_o` are combinational from `dmem_ready_i`/`dmem_rdata_i` and `grant_q`.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {ArbIdle, ArbBusy} arb_state_e`
  - request struct `mem_req_t` with addr, wdata, wstrb, write, read, parameterised by the package's default widths.
- Sub-module `rr_picker`: combinational, parameter `NUM_REQ`.
  - Inputs: `active` vector, `last_grant` index.
  - Outputs: one-hot `pick`, `pick_idx`, `any`.
- Top level holds the FSM, the `req_q`/`grant_q`/`last_grant` registers and the output muxing.

## Test plan
- Reset: hold `rst_n` low, then release. All outputs are 0. Read request from requester 1 only at addr 0x100: `grant_o`=2'b10, then `dmem_read_o`=1 with `dmem_addr_o`=0x100. With `dmem_ready_i`=1 and rdata 0xDEADBEEF, `req_ready_o`=2'b10 and `req_rdata_o`=0xDEADBEEF.
- Both requesters continuously active for 6 transactions with an immediately-ready memory → grants 0,1,0,1,0,1, ready every 2 cycles.
- Write with wstrb 4'b0011, wdata 0x12345678 at 0x40, memory stalled 5 cycles → `dmem_*` stable for all 5 cycles. Requester 0 drops its inputs at cycle 2; the `dmem` outputs are unchanged and ready is still returned to 0.
- Both `req_write_i[0]` and `req_read_i[0]` set → `dmem_write_o`=1 and `dmem_read_o`=0.
- Assert `rst_n` low during ArbBusy → all outputs 0 immediately. After release, a simultaneous request from both requesters grants 0 first.
- `dmem_ready_i` pulsed in ArbIdle → no `req_ready_o` and no state change.
